simplebus_initiator: RTL and testbench
======================================

# simplebus_initiator

Synthesizable leader-side engine for the simplebus: accepts 24-bit read/write requests on a valid/ready port, runs the three-phase address sequence (upper, mid, low byte), then either waits for follower `dataValid` (read) or drives one write-data beat. It returns a response on a valid/ready port. It sits between a processor core and the `simplebus` leader modport, and replaces task-driven bus access. The top level resolves the `*_oe` pairs onto the tri-state `data`, `dataValid` and `address` nets.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum read-wait cycles before error (only with macro); must be ≥2.
- `clock` in 1: bus clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge where both are high.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 24: byte address; `[23:16]` selects the follower.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: response consumed on an edge where both are high.
- `rsp_rdata` out 8: read data; 8'h00 for writes.
- `rsp_err` out 1: read timed out (0 without macro).
- `bus_start` out 1: simplebus `start`.
- `bus_read` out 1: simplebus `read`.
- `bus_addr` / `bus_addr_oe` out 8 / 1: address byte and its drive enable.
- `bus_data_out` / `bus_data_oe` out 8 / 1: write data and its drive enable.
- `bus_data_in` in 8: resolved `data` net.
- `bus_dv_out` / `bus_dv_oe` out 1 / 1: `dataValid` value and its drive enable.
- `bus_dv_in` in 1: resolved `dataValid` net.

## Operation
- **States:** IDLE, UP, MID, LO, RDW, WR.
- **Request handshake:** `req_ready` = (IDLE && !rsp_valid), combinational. On accept, latch addr, wdata and write into internal regs, then go to UP.
- **UP:** `bus_start`=1, `bus_addr`=addr[23:16], oe=1. Go to MID.
- **MID:** `bus_addr`=addr[15:8], oe=1. Go to LO.
- **LO:** `bus_addr`=addr[7:0], oe=1, `bus_read`=!write. Go to RDW if read, else WR.
- **RDW:** drive nothing; wait for `bus_dv_in`=1.
  - On an edge with `bus_dv_in`=1: capture `bus_data_in` into `rsp_rdata`, set `rsp_valid`, `rsp_err`=0, go to IDLE.
- **WR:** `bus_data_out`=wdata, `bus_data_oe`=1, `bus_dv_out`=1, `bus_dv_oe`=1 for exactly one cycle. Then set `rsp_valid` (`rsp_rdata`=0, `rsp_err`=0) and go to IDLE.
- **Response handshake:** `rsp_valid` clears on an edge with `rsp_ready`=1. No new request is accepted while a response is pending.
- **Bus outputs outside their phases:** all oe=0; `bus_addr`, `bus_data_out`, `bus_dv_out`, `bus_start`, `bus_read` = 0. The block never drives `dataValid` in RDW.
- **Reset (async, including mid-transaction):** state=IDLE; all bus outputs and oe=0; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; latched request regs=0. An in-flight transaction is dropped with no response.

## Timing
- Accept edge = edge 0. UP occupies cycle 1, MID cycle 2, LO cycle 3.
- **Write:** WR in cycle 4; `rsp_valid` high from cycle 5. Fixed 5-cycle latency.
- **Read:** RDW from cycle 4. If `bus_dv_in` is high in cycle 4+k, `rsp_valid` is high from cycle 5+k. Minimum latency is 5.
- **Back-to-back:** `rsp_ready` held high gives `rsp_valid` a 1-cycle pulse. `req_ready` rises in the following cycle, so the next UP is no earlier than 2 cycles after the response.
- `bus_dv_in` outside RDW is ignored.

## Configuration
- **`SIMPLEBUS_INIT_TIMEOUT_EN` defined:**
  - A wait counter of width $clog2(TIMEOUT_CYCLES) clears on entry to RDW and increments in each RDW cycle with `bus_dv_in`=0.
  - In the RDW cycle where the counter equals TIMEOUT_CYCLES-1 and `bus_dv_in`=0: go to IDLE with `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=8'hFF.
  - `bus_dv_in`=1 in that same cycle wins: normal data, `rsp_err`=0.
  - RDW therefore lasts at most TIMEOUT_CYCLES cycles.
- **Undefined:** no counter; RDW waits indefinitely; `rsp_err` is tied 0.

## Test plan
- **Write:** write 0x010406 ← 0xDC. Expect `bus_start` only in cycle 1; `bus_addr` 0x01, 0x04, 0x06 in cycles 1–3; `bus_read`=0; cycle 4 drives data 0xDC with dv=1 and both oe=1; `rsp_valid` in cycle 5 with err=0.
- **Read:** read 0x010406 with follower dv after 3 wait cycles, data 0xDC. Expect `bus_read`=1 in LO only, `rsp_rdata`=0xDC, `rsp_valid` in cycle 8, no leader drive of `dataValid`.
- **Backpressure:** hold `rsp_ready`=0 for 4 cycles after a response with `req_valid` high. Expect `req_ready`=0 and the response stable throughout. Accept the next request only after `rsp_ready`.
- **Timeout (macro on, TIMEOUT_CYCLES=4):** read 0x020000 with no follower. Expect `rsp_valid` in cycle 8, `rsp_err`=1, `rsp_rdata`=0xFF. With dv in the 4th RDW cycle instead: normal data, err=0.
- **Reset mid-transaction:** assert `reset` during MID. Expect all oe low immediately (async), no response, and a clean next transaction.
- **Back-to-back:** write 0x010407 ← 0xAB, read 0x010407, write 0x010406 ← 0xF1, read 0x010406 against the memory follower with N=1. Expect reads to return 0xAB and 0xF1.

Source files
------------

// File: rtl/simplebus_initiator.sv
// Leader-side simplebus engine: request port -> three-phase address -> read wait or write beat -> response port.
// Optional read-wait timeout enabled by defining SIMPLEBUS_INIT_TIMEOUT_EN (parameter TIMEOUT_CYCLES, >= 2).
module simplebus_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        bus_start,
    output logic        bus_read,
    output logic [7:0]  bus_addr,
    output logic        bus_addr_oe,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    input  logic [7:0]  bus_data_in,
    output logic        bus_dv_out,
    output logic        bus_dv_oe,
    input  logic        bus_dv_in
);

    typedef enum logic [2:0] {IDLE, UP, MID, LO, RDW, WR} state_e;

    state_e      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        accept;

`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
            wait_q      <= wait_d;
`endif
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
        wait_d       = wait_q;
`endif
        req_ready    = (state_q == IDLE) && !rsp_valid_q;
        accept       = req_valid && req_ready;
        bus_start    = 1'b0;
        bus_read     = 1'b0;
        bus_addr     = '0;
        bus_addr_oe  = 1'b0;
        bus_data_out = '0;
        bus_data_oe  = 1'b0;
        bus_dv_out   = 1'b0;
        bus_dv_oe    = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    state_d = UP;
                end
            end
            UP: begin
                bus_start   = 1'b1;
                bus_addr    = addr_q[23:16];
                bus_addr_oe = 1'b1;
                state_d     = MID;
            end
            MID: begin
                bus_addr    = addr_q[15:8];
                bus_addr_oe = 1'b1;
                state_d     = LO;
            end
            LO: begin
                bus_addr    = addr_q[7:0];
                bus_addr_oe = 1'b1;
                bus_read    = !write_q;
                state_d     = write_q ? WR : RDW;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
                wait_d      = '0;
`endif
            end
            RDW: begin
                // Follower data wins over a timeout landing in the same cycle.
                if (bus_dv_in) begin
                    rsp_rdata_d = bus_data_in;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    rsp_rdata_d = 8'hFF;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            WR: begin
                bus_data_out = wdata_q;
                bus_data_oe  = 1'b1;
                bus_dv_out   = 1'b1;
                bus_dv_oe    = 1'b1;
                rsp_rdata_d  = '0;
                rsp_valid_d  = 1'b1;
                rsp_err_d    = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_simplebus_initiator.sv
// Directed bench for simplebus_initiator: scoreboard of expected responses plus a behavioural memory follower.
// Define SIMPLEBUS_INIT_TIMEOUT_EN to also exercise the read timeout with TIMEOUT_CYCLES=4.
module tb_simplebus_initiator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        bus_start;
    logic        bus_read;
    logic [7:0]  bus_addr;
    logic        bus_addr_oe;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic [7:0]  bus_data_in = 8'hEE;
    logic        bus_dv_out;
    logic        bus_dv_oe;
    logic        bus_dv_in = 1'b0;

    simplebus_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_start(bus_start), .bus_read(bus_read), .bus_addr(bus_addr), .bus_addr_oe(bus_addr_oe),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in),
        .bus_dv_out(bus_dv_out), .bus_dv_oe(bus_dv_oe), .bus_dv_in(bus_dv_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    // Follower model state, shared with the directed sequence through these knobs.
    logic [7:0]  mem [logic [23:0]];
    logic        f_en = 1'b1;
    int          f_wait = 1;
    logic        leader_dv_seen = 1'b0;

    // Memory follower: decodes the address phases on the falling edge and answers reads after f_wait cycles.
    initial begin
        int          phase;
        int          cnt;
        logic [23:0] f_addr;
        phase  = 0;
        cnt    = 0;
        f_addr = '0;
        forever begin
            @(negedge clock);
            bus_dv_in   = 1'b0;
            bus_data_in = 8'hEE;
            if (reset) begin
                phase = 0;
            end else if (bus_start && bus_addr_oe) begin
                f_addr[23:16] = bus_addr;
                phase = 1;
            end else begin
                case (phase)
                    1: if (bus_addr_oe) begin f_addr[15:8] = bus_addr; phase = 2; end else phase = 0;
                    2: if (bus_addr_oe) begin
                           f_addr[7:0] = bus_addr;
                           phase = bus_read ? 3 : 4;
                           cnt = f_wait;
                       end else phase = 0;
                    3: begin
                           if (bus_dv_oe) leader_dv_seen = 1'b1;
                           if (!f_en) phase = 0;
                           else if (cnt == 0) begin
                               bus_dv_in   = 1'b1;
                               bus_data_in = mem.exists(f_addr) ? mem[f_addr] : 8'h00;
                               phase = 0;
                           end else cnt--;
                       end
                    4: begin
                           if (bus_data_oe && bus_dv_oe && bus_dv_out) mem[f_addr] = bus_data_out;
                           phase = 0;
                       end
                    default: phase = 0;
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [7:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic pop_rsp(input string tag);
        rsp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
            check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        end
    endtask

    // Presents a request and returns one step after the accepting edge (cycle 1).
    task automatic do_accept(input string tag, input logic wr, input logic [23:0] a, input logic [7:0] d);
        int n;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n;
        n = 0;
        while (!rsp_valid && n < budget) begin step(); n++; end
        check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
    endtask

    logic        b2b_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [23:0] b2b_addr [4] = '{24'h010407, 24'h010407, 24'h010406, 24'h010406};
    logic [7:0]  b2b_wd   [4] = '{8'hAB, 8'h00, 8'hF1, 8'h00};
    logic [7:0]  b2b_exp  [4] = '{8'h00, 8'hAB, 8'h00, 8'hF1};

    initial begin
        mem[24'h020000] = 8'h5A;

        // Reset state
        step();
        step();
        check("rst_addr_oe", 32'(bus_addr_oe), 32'd0);
        check("rst_data_oe", 32'(bus_data_oe), 32'd0);
        check("rst_dv_oe", 32'(bus_dv_oe), 32'd0);
        check("rst_start", 32'(bus_start), 32'd0);
        reset = 1'b0;
        step();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Write 0x010406 <- 0xDC, cycle-exact
        push_exp(8'h00, 1'b0);
        do_accept("wr", 1'b1, 24'h010406, 8'hDC);
        check("wr_c1_start", 32'(bus_start), 32'd1);
        check("wr_c1_addr", 32'(bus_addr), 32'h01);
        check("wr_c1_oe", 32'(bus_addr_oe), 32'd1);
        check("wr_c1_read", 32'(bus_read), 32'd0);
        step();
        check("wr_c2_start", 32'(bus_start), 32'd0);
        check("wr_c2_addr", 32'(bus_addr), 32'h04);
        check("wr_c2_oe", 32'(bus_addr_oe), 32'd1);
        step();
        check("wr_c3_addr", 32'(bus_addr), 32'h06);
        check("wr_c3_read", 32'(bus_read), 32'd0);
        step();
        check("wr_c4_data", 32'(bus_data_out), 32'hDC);
        check("wr_c4_data_oe", 32'(bus_data_oe), 32'd1);
        check("wr_c4_dv", 32'(bus_dv_out), 32'd1);
        check("wr_c4_dv_oe", 32'(bus_dv_oe), 32'd1);
        check("wr_c4_addr_oe", 32'(bus_addr_oe), 32'd0);
        check("wr_c4_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        check("wr_c5_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_c5_data_oe", 32'(bus_data_oe), 32'd0);
        pop_rsp("wr");
        check("wr_mem", 32'(mem[24'h010406]), 32'hDC);
        release_rsp("wr");

        // Read 0x010406 with three follower wait cycles
        f_en = 1'b1;
        f_wait = 3;
        leader_dv_seen = 1'b0;
        push_exp(8'hDC, 1'b0);
        do_accept("rd", 1'b0, 24'h010406, 8'h00);
        check("rd_c1_read", 32'(bus_read), 32'd0);
        step();
        check("rd_c2_read", 32'(bus_read), 32'd0);
        step();
        check("rd_c3_read", 32'(bus_read), 32'd1);
        check("rd_c3_addr", 32'(bus_addr), 32'h06);
        for (int c = 4; c <= 7; c++) begin
            step();
            check($sformatf("rd_c%0d_rsp_valid", c), 32'(rsp_valid), 32'd0);
            check($sformatf("rd_c%0d_dv_oe", c), 32'(bus_dv_oe), 32'd0);
            check($sformatf("rd_c%0d_read", c), 32'(bus_read), 32'd0);
        end
        step();
        check("rd_c8_rsp_valid", 32'(rsp_valid), 32'd1);
        pop_rsp("rd");
        check("rd_no_leader_dv", 32'(leader_dv_seen), 32'd0);
        release_rsp("rd");

        // Backpressure: response held with a new request waiting
        f_wait = 1;
        push_exp(8'hDC, 1'b0);
        do_accept("bp", 1'b0, 24'h010406, 8'h00);
        wait_rsp("bp", 20);
        pop_rsp("bp");
        push_exp(8'h00, 1'b0);
        req_write = 1'b1;
        req_addr  = 24'h0104FF;
        req_wdata = 8'h3C;
        req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp_hold%0d_req_ready", c), 32'(req_ready), 32'd0);
            check($sformatf("bp_hold%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_hold%0d_rdata", c), 32'(rsp_rdata), 32'hDC);
            check($sformatf("bp_hold%0d_start", c), 32'(bus_start), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
        check("bp_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("bp_next_start", 32'(bus_start), 32'd1);
        check("bp_next_addr", 32'(bus_addr), 32'h01);
        wait_rsp("bp2", 20);
        pop_rsp("bp2");
        check("bp2_mem", 32'(mem[24'h0104FF]), 32'h3C);
        release_rsp("bp2");

`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
        // Timeout with no follower, then data arriving in the last allowed RDW cycle
        f_en = 1'b0;
        push_exp(8'hFF, 1'b1);
        do_accept("to", 1'b0, 24'h020000, 8'h00);
        for (int c = 2; c <= 7; c++) begin
            step();
            check($sformatf("to_c%0d_rsp_valid", c), 32'(rsp_valid), 32'd0);
        end
        step();
        check("to_c8_rsp_valid", 32'(rsp_valid), 32'd1);
        pop_rsp("to");
        release_rsp("to");

        f_en = 1'b1;
        f_wait = 3;
        push_exp(8'h5A, 1'b0);
        do_accept("to_dv", 1'b0, 24'h020000, 8'h00);
        for (int c = 2; c <= 7; c++) begin
            step();
            check($sformatf("to_dv_c%0d_rsp_valid", c), 32'(rsp_valid), 32'd0);
        end
        step();
        check("to_dv_c8_rsp_valid", 32'(rsp_valid), 32'd1);
        pop_rsp("to_dv");
        release_rsp("to_dv");
`endif

        // Reset asserted during MID
        f_en = 1'b1;
        f_wait = 1;
        push_exp(8'hDC, 1'b0);
        do_accept("mrst", 1'b0, 24'h010406, 8'h00);
        step();
        check("mrst_mid_oe", 32'(bus_addr_oe), 32'd1);
        check("mrst_mid_addr", 32'(bus_addr), 32'h04);
        reset = 1'b1;
        #1;
        sb_q.delete(sb_q.size() - 1);
        check("mrst_async_addr_oe", 32'(bus_addr_oe), 32'd0);
        check("mrst_async_addr", 32'(bus_addr), 32'd0);
        check("mrst_async_read", 32'(bus_read), 32'd0);
        check("mrst_async_dv_oe", 32'(bus_dv_oe), 32'd0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("mrst_norsp%0d", c), 32'(rsp_valid), 32'd0);
            check($sformatf("mrst_idle_oe%0d", c), 32'(bus_addr_oe), 32'd0);
        end

        // Back-to-back with rsp_ready held high
        f_wait = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n;
            push_exp(b2b_exp[i], 1'b0);
            req_write = b2b_wr[i];
            req_addr  = b2b_addr[i];
            req_wdata = b2b_wd[i];
            req_valid = 1'b1;
            if (i > 0) begin
                check($sformatf("b2b%0d_rsp_cycle_req_ready", i), 32'(req_ready), 32'd0);
                step();
                check($sformatf("b2b%0d_rsp_pulse", i), 32'(rsp_valid), 32'd0);
                check($sformatf("b2b%0d_req_ready", i), 32'(req_ready), 32'd1);
                check($sformatf("b2b%0d_no_early_start", i), 32'(bus_start), 32'd0);
            end
            n = 0;
            while (!req_ready && n < 50) begin step(); n++; end
            step();
            req_valid = 1'b0;
            check($sformatf("b2b%0d_start", i), 32'(bus_start), 32'd1);
            check($sformatf("b2b%0d_addr_hi", i), 32'(bus_addr), 32'h01);
            wait_rsp($sformatf("b2b%0d", i), 20);
            pop_rsp($sformatf("b2b%0d", i));
        end
        step();
        check("b2b_last_pulse", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
